// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory request/response bus for fetch_ctrl
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch controller with CP0 redirect and halt
// Optional: FETCH_ALIGN_CHECK_EN presents misaligned PCs as address-error entries without a memory request.
module fetch_ctrl #(
   parameter logic [31:0] TEXT_START  = 32'h0000_3000,
   parameter logic [31:0] KTEXT_START = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] npc,
   input  logic        k_redirect,
   input  logic [31:0] k_target,
   fetch_ctrl_if.master imem,
   output logic [31:0] pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic        if_adel,
   output logic        halted
);
   localparam logic [31:0] TERM_PC = KTEXT_START - 32'd4;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

   state_t      state, state_d;
   logic [31:0] pc_d, instr_d, enter_pc;
   logic        valid_d, kill, kill_d, halted_d, enter_req;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        mis_d;
`endif

   assign imem.imem_req  = (state == S_REQ);
   assign imem.imem_addr = {pc[31:2], 2'b00};

   always_comb begin
      state_d   = state;
      pc_d      = pc;
      valid_d   = if_valid;
      instr_d   = if_instr;
      kill_d    = kill;
      halted_d  = halted;
      enter_req = 1'b0;
      enter_pc  = pc;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_d     = 1'b0;
`endif
      case (state)
         S_REQ: begin
            if (imem.imem_ready) begin
               state_d = S_WAIT;
               if (k_redirect) begin
                  pc_d   = k_target;
                  kill_d = 1'b1;
               end
            end else if (k_redirect) begin
               enter_req = 1'b1;
               enter_pc  = k_target;
            end
         end
         S_WAIT: begin
            // a redirect coinciding with the response discards it directly; otherwise wait it out
            if (k_redirect) begin
               pc_d = k_target;
               if (imem.imem_rvalid) begin
                  kill_d    = 1'b0;
                  enter_req = 1'b1;
                  enter_pc  = k_target;
               end else begin
                  kill_d = 1'b1;
               end
            end else if (imem.imem_rvalid) begin
               if (kill) begin
                  kill_d    = 1'b0;
                  enter_req = 1'b1;
                  enter_pc  = pc;
               end else begin
                  state_d = S_HOLD;
                  valid_d = 1'b1;
                  instr_d = imem.imem_rdata;
               end
            end
         end
         S_HOLD: begin
            if (k_redirect) begin
               valid_d   = 1'b0;
               enter_req = 1'b1;
               enter_pc  = k_target;
            end else if (!stall) begin
               valid_d   = 1'b0;
               enter_req = 1'b1;
               enter_pc  = npc;
            end
         end
         default: ;
      endcase

      if (enter_req) begin
         pc_d    = enter_pc;
         state_d = S_REQ;
         if (enter_pc == TERM_PC) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            valid_d  = 1'b0;
         end
`ifdef FETCH_ALIGN_CHECK_EN
         else if (enter_pc[1:0] != 2'b00) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            instr_d = '0;
            mis_d   = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_REQ;
         pc       <= TEXT_START;
         if_valid <= 1'b0;
         if_instr <= '0;
         kill     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_d;
         pc       <= pc_d;
         if_valid <= valid_d;
         if_instr <= instr_d;
         kill     <= kill_d;
         halted   <= halted_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   // the error flag lives exactly as long as the entry it marks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_adel <= 1'b0;
      end else begin
         if_adel <= mis_d | (if_adel & valid_d);
      end
   end
`else
   assign if_adel = 1'b0;
`endif
endmodule
